// File: rtl/qtcore_pkg.sv
// Shared definitions for the qtcore memory bank and its scan-chain loader.
package qtcore_pkg;

  // Total scan-chain length: 31 memory bytes + 1 btn bit + 7 LED bits.
  localparam int SCAN_CHAIN_LEN = 256;
  localparam int MEM_BYTES      = 31;
  // Byte slot holding the btn/LED bits, at the scan_out end of the chain.
  localparam int IO_ADDR        = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/piso_sipo_byte.sv
// Byte serialiser/deserialiser: a parallel-load transmit register shifted out
// MSB first, paired with a serial-in receive register sharing one bit counter.
module piso_sipo_byte #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_load_data,
  input  logic              i_shift,
  input  logic              i_ser_in,
  output logic              o_ser_out,
  output logic              o_last_bit,
  output logic [BYTE_W-1:0] o_par_out,
  output logic              o_par_valid
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  logic [BYTE_W-1:0] r_shreg;
  logic [BYTE_W-1:0] r_rbreg;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_par_out;
  logic              r_par_valid;
  logic [BYTE_W-1:0] w_rb_shifted;

  // The incoming bit is the one presented before the shifting edge.
  assign w_rb_shifted = {r_rbreg[BYTE_W-2:0], i_ser_in};
  assign o_last_bit   = (r_bit_cnt == CNT_W'(BYTE_W - 1));
  assign o_ser_out    = r_shreg[BYTE_W-1];
  assign o_par_out    = r_par_out;
  assign o_par_valid  = r_par_valid;

  // Load/shift datapath; bit counter parks on the last bit until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_rbreg     <= '0;
      r_bit_cnt   <= '0;
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
    end else begin
      r_par_valid <= 1'b0;
      if (i_clear) begin
        r_rbreg   <= '0;
        r_bit_cnt <= '0;
      end else if (i_load) begin
        r_shreg   <= i_load_data;
        r_bit_cnt <= '0;
      end else if (i_shift) begin
        r_shreg <= {r_shreg[BYTE_W-2:0], 1'b0};
        r_rbreg <= w_rb_shifted;
        if (o_last_bit) begin
          r_par_out   <= w_rb_shifted;
          r_par_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Streams a program image byte by byte into the memory bank scan chain,
// returns the displaced chain contents as readback bytes and holds the CPU
// for the duration of the load.
module scan_chain_loader
  import qtcore_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
  parameter int BYTE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_scan_en,
  output logic              o_mem_scan_in,
  input  logic              i_mem_scan_out,
  output logic [BYTE_W-1:0] o_rb_byte,
  output logic              o_rb_valid,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done
);

  localparam int NUM_BYTES = CHAIN_LEN / BYTE_W;
  localparam int BCNT_W    = $clog2(NUM_BYTES) + 1;

  loader_state_t     r_state;
  logic [BCNT_W-1:0] r_byte_cnt;
  logic              r_byte_ready;
  logic              r_scan_en;
  logic              r_busy;
  logic              r_done;

  logic w_start_ok;
  logic w_accept;
  logic w_last_bit;

  // Ready is a registered state flag, so it never depends on byte_valid.
  assign w_start_ok = (r_state == IDLE) && i_start;
  assign w_accept   = (r_state == LOAD) && i_byte_valid;

  assign o_byte_ready  = r_byte_ready;
  assign o_mem_scan_en = r_scan_en;
  assign o_busy        = r_busy;
  assign o_cpu_hold    = r_busy;
  assign o_done        = r_done;

  piso_sipo_byte #(
    .BYTE_W (BYTE_W)
  ) u_piso_sipo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_load      (w_accept),
    .i_load_data (i_byte_in),
    .i_shift     (r_scan_en),
    .i_ser_in    (i_mem_scan_out),
    .o_ser_out   (o_mem_scan_in),
    .o_last_bit  (w_last_bit),
    .o_par_out   (o_rb_byte),
    .o_par_valid (o_rb_valid)
  );

  // Loader FSM with registered ready/scan_en/busy/done; byte_cnt counts accepted bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_byte_cnt   <= '0;
      r_byte_ready <= 1'b0;
      r_scan_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state      <= LOAD;
            r_byte_cnt   <= '0;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (i_byte_valid) begin
            r_state      <= SHIFT;
            r_byte_cnt   <= r_byte_cnt + 1'b1;
            r_byte_ready <= 1'b0;
            r_scan_en    <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_last_bit) begin
            r_scan_en <= 1'b0;
            if (r_byte_cnt == BCNT_W'(NUM_BYTES)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= LOAD;
              r_byte_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_scan_en    <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: random images loaded into a behavioural
// 256-bit scan chain, with final contents and readback compared against
// the expected byte placement.
module tb_scan_chain_loader;
  import qtcore_pkg::*;

  localparam int BW = 8;
  localparam int NB = SCAN_CHAIN_LEN / BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [BW-1:0] i_byte_in = '0;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready, o_mem_scan_en, o_mem_scan_in, i_mem_scan_out;
  logic [BW-1:0] o_rb_byte;
  logic          o_rb_valid, o_busy, o_cpu_hold, o_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SCAN_CHAIN_LEN-1:0] chain;
  logic [BW-1:0]             img [NB];

  always #5 clk = ~clk;

  scan_chain_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_byte_in      (i_byte_in),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_mem_scan_en  (o_mem_scan_en),
    .o_mem_scan_in  (o_mem_scan_in),
    .i_mem_scan_out (i_mem_scan_out),
    .o_rb_byte      (o_rb_byte),
    .o_rb_valid     (o_rb_valid),
    .o_busy         (o_busy),
    .o_cpu_hold     (o_cpu_hold),
    .o_done         (o_done)
  );

  // Memory bank stand-in: scan_in enters at address 0, scan_out leaves from the IO byte.
  always @(posedge clk) begin
    if (o_mem_scan_en) chain <= {chain[SCAN_CHAIN_LEN-2:0], o_mem_scan_in};
  end
  assign i_mem_scan_out = chain[SCAN_CHAIN_LEN-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".scan_en"}, 32'(o_mem_scan_en), 0);
    check({tag, ".busy"},    32'(o_busy), 0);
    check({tag, ".hold"},    32'(o_cpu_hold), 0);
    check({tag, ".ready"},   32'(o_byte_ready), 0);
    check({tag, ".done"},    32'(o_done), 0);
    check({tag, ".rbv"},     32'(o_rb_valid), 0);
    check({tag, ".rbbyte"},  32'(o_rb_byte), 0);
  endtask

  // One complete load of img[]; abort_at >= 0 asserts reset during that scan bit.
  task automatic run_load(input string name, input int gap_len, input bit restart7,
                          input int abort_at, input int stall_pct);
    logic [SCAN_CHAIN_LEN-1:0] snap;
    logic [BW-1:0] rb[$];
    int idx = 0, en_cnt = 0, done_cyc = -1, done_cnt = 0, stall_cycles = 0;
    int gap_left = gap_len, gap_en = 0, bad_en = 0, bad_busy = 0, rb_at_done = 0;
    bit restarted = 0, aborted = 0, v;
    snap = chain;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_mem_scan_en) en_cnt++;
      if (o_byte_ready && o_mem_scan_en) bad_en++;
      if (o_busy !== 1'b1 || o_cpu_hold !== o_busy) bad_busy++;
      if (o_rb_valid) rb.push_back(o_rb_byte);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        rb_at_done = int'(o_rb_valid);
        break;
      end
      if (abort_at >= 0 && o_mem_scan_en && en_cnt == abort_at + 1) begin
        #1 rst_n = 1'b0;
        #1 check_idle_outputs({name, ".async_rst"});
        i_byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      v = 0;
      if (idx < NB) begin
        if (o_byte_ready && idx == 10 && gap_left > 0) begin
          gap_left--;
          v = 0;
        end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
          v = 0;
        end else begin
          v = 1;
        end
      end
      if (o_byte_ready && !v && idx < NB) stall_cycles++;
      if (gap_len > 0 && idx == 10 && o_byte_ready && !v && o_mem_scan_en) gap_en++;
      i_byte_valid = v;
      i_byte_in    = v ? img[idx] : BW'($urandom);
      if (v && o_byte_ready) idx++;
      if (restart7 && !restarted && idx == 8 && o_mem_scan_en) begin
        i_start   = 1'b1;
        restarted = 1;
      end
    end
    i_byte_valid = 1'b0;
    if (aborted) begin
      $display("[TB] %s: reset asserted at scan bit %0d", name, abort_at);
      return;
    end
    check({name, ".done_seen"}, 32'(done_cnt), 1);
    check({name, ".done_cyc"}, 32'(done_cyc), 32'(1 + NB * (BW + 1) + stall_cycles));
    check({name, ".scan_cycles"}, 32'(en_cnt), 32'(SCAN_CHAIN_LEN));
    check({name, ".scan_in_load"}, 32'(bad_en), 0);
    check({name, ".gap_scan"}, 32'(gap_en), 0);
    check({name, ".busy_hold"}, 32'(bad_busy), 0);
    check({name, ".rb_at_done"}, 32'(rb_at_done), 1);
    check({name, ".rb_count"}, 32'(rb.size()), 32'(NB));
    for (int k = 0; k < NB && k < rb.size(); k++)
      check($sformatf("%s.rb[%0d]", name, k), 32'(rb[k]),
            32'(snap[SCAN_CHAIN_LEN-1-BW*k -: BW]));
    for (int a = 0; a < MEM_BYTES; a++)
      check($sformatf("%s.mem[%0d]", name, a), 32'(chain[BW*a +: BW]), 32'(img[NB-1-a]));
    check({name, ".io"}, 32'(chain[BW*IO_ADDR +: BW]), 32'(img[0]));
    @(negedge clk);
    check({name, ".busy_fall"}, 32'(o_busy), 0);
    check({name, ".hold_fall"}, 32'(o_cpu_hold), 0);
    check({name, ".done_pulse"}, 32'(o_done), 0);
    $display("[TB] %s: done at cycle %0d, %0d stall cycles, %0d readback bytes",
             name, done_cyc, stall_cycles, rb.size());
  endtask

  task automatic rand_img();
    for (int k = 0; k < NB; k++) img[k] = BW'($urandom);
  endtask

  initial begin
    for (int w = 0; w < SCAN_CHAIN_LEN / 32; w++) chain[32*w +: 32] = $urandom;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during bit 3 of byte 5, then a full reload.
    rand_img();
    run_load("abort", 0, 0, 5 * BW + 3, 0);
    check_idle_outputs("post_abort");
    run_load("reload", 0, 0, -1, 0);

    // Counting image, loaded twice so the second readback returns it.
    for (int k = 0; k < NB; k++) img[k] = BW'(k);
    run_load("count1", 0, 0, -1, 0);
    check("count1.mem0", 32'(chain[7:0]), 32'h1f);
    check("count1.mem30", 32'(chain[BW*30 +: BW]), 32'h01);
    run_load("count2", 0, 0, -1, 0);

    rand_img();
    run_load("gap20", 20, 0, -1, 0);
    rand_img();
    run_load("restart", 0, 1, -1, 0);
    for (int r = 0; r < 3; r++) begin
      rand_img();
      run_load($sformatf("stall%0d", r), 0, 0, -1, 30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
